// File: rtl/lemming_dig_arbiter_if.sv
// Shovel arbitration bundle between the lemming walker FSMs and the arbiter.
// Walkers drive the request vector; the arbiter returns the registered grant,
// the owner index, the busy flag and the forced-release pulse.
interface lemming_dig_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic            timeout;

    // Walker side: raises requests, observes the grant.
    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );

    // Arbiter side: samples requests, drives the grant.
    modport slave (
        input  req,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/lemming_dig_arbiter.sv
// Round-robin arbiter for the single dig shovel shared by N walker FSMs.
// One owner at a time, bounded hold time (MAX_HOLD), and a one-cycle
// cooldown between owners. After an owner leaves, the round-robin start
// moves past it so that owner has the lowest priority next time.
module lemming_dig_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 20,
    parameter int ID_W     = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    lemming_dig_arbiter_if.slave arb
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N - 1);
    localparam logic [ID_W-1:0] IDX_ONE  = ID_W'(1);
    localparam logic [ID_W:0]   N_EXT    = (ID_W + 1)'(N);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_ONE = HC_W'(1);
    localparam logic [N-1:0]    ONE_HOT0 = N'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t          state_r;
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] owner_r;
    logic [HC_W-1:0] hold_cnt_r;
    logic [N-1:0]    grant_r;
    logic [ID_W-1:0] grant_id_r;
    logic            busy_r;
    logic            timeout_r;

    logic            sel_found_s;
    logic [ID_W-1:0] sel_idx_s;
    logic [ID_W:0]   cand_s;
    logic [ID_W:0]   sum_s;
    logic            owner_req_s;

    // The owner's own request line decides between staying and releasing.
    assign owner_req_s = arb.req[owner_r];

    // Rotating-priority search: first requester at ptr, ptr+1, ... wrapping mod N.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        sum_s       = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single conditional subtract wraps correctly
            // and never produces an index >= N.
            sum_s  = {1'b0, ptr_r} + (ID_W + 1)'(k);
            cand_s = (sum_s >= N_EXT) ? (sum_s - N_EXT) : sum_s;
            if (!sel_found_s && arb.req[cand_s[ID_W-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s[ID_W-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Arbitration FSM with all outputs registered alongside the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            owner_r    <= '0;
            hold_cnt_r <= '0;
            grant_r    <= '0;
            grant_id_r <= '0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout_r <= 1'b0;
                    if (sel_found_s) begin
                        state_r    <= GRANT;
                        owner_r    <= sel_idx_s;
                        hold_cnt_r <= HOLD_ONE;
                        grant_r    <= ONE_HOT0 << sel_idx_s;
                        grant_id_r <= sel_idx_s;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req_s || (hold_cnt_r == HOLD_MAX)) begin
                        state_r    <= COOLDOWN;
                        ptr_r      <= (owner_r == LAST_IDX) ? '0 : (owner_r + IDX_ONE);
                        grant_r    <= '0;
                        grant_id_r <= '0;
                        busy_r     <= 1'b0;
                        // Reaching here with the request still high means the
                        // hold limit forced the release.
                        timeout_r  <= owner_req_s;
                    end else begin
                        state_r    <= GRANT;
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        timeout_r  <= 1'b0;
                    end
                end
                COOLDOWN: begin
                    state_r   <= IDLE;
                    timeout_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    grant_r    <= '0;
                    grant_id_r <= '0;
                    busy_r     <= 1'b0;
                    timeout_r  <= 1'b0;
                end
            endcase
        end
    end

    assign arb.grant    = grant_r;
    assign arb.grant_id = grant_id_r;
    assign arb.busy     = busy_r;
    assign arb.timeout  = timeout_r;

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Bench for lemming_dig_arbiter: a cycle-level reference model pushes the
// expected outputs into a queue on every clock edge, and a monitor pops and
// compares them shortly after the edge. Directed scenarios add checks against
// fixed expected values, followed by a randomized request phase.
module tb_lemming_dig_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 20;
    localparam int ID_W     = 2;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    lemming_dig_arbiter_if #(.N(N), .ID_W(ID_W)) arb();

    lemming_dig_arbiter #(
        .N(N), .MAX_HOLD(MAX_HOLD), .ID_W(ID_W)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .arb(arb)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] grant;
        int           id;
        logic         busy;
        logic         to;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: owner index (-1 = none), cycles held, cooldown cycles
    // left, and the walker that has highest priority in the next arbitration.
    int   m_own;
    int   m_held;
    int   m_gap;
    int   m_prio;
    logic m_to;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic m_reset();
        m_own  = -1;
        m_held = 0;
        m_gap  = 0;
        m_prio = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        m_to = 1'b0;
        if (m_own >= 0) begin
            if (!r[m_own] || m_held == MAX_HOLD) begin
                m_to   = r[m_own];
                m_prio = (m_own + 1) % N;
                m_own  = -1;
                m_gap  = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_own < 0 && r[(m_prio + k) % N]) begin
                    m_own  = (m_prio + k) % N;
                    m_held = 1;
                end
            end
        end
    endtask

    // Model: advance on every edge and queue the expected post-edge outputs.
    initial begin
        exp_t e;
        m_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                m_reset();
                exp_q.delete();
            end else begin
                model_step(arb.req);
                e.grant = '0;
                if (m_own >= 0) e.grant[m_own] = 1'b1;
                e.id   = (m_own >= 0) ? m_own : 0;
                e.busy = (m_own >= 0);
                e.to   = m_to;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: pop and compare the queued expectation just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_grant",    int'(arb.grant),    int'(e.grant));
                chk("sb_grant_id", int'(arb.grant_id), e.id);
                chk("sb_busy",     int'(arb.busy),     int'(e.busy));
                chk("sb_timeout",  int'(arb.timeout),  int'(e.to));
            end
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        arb.req   = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Directed scenarios followed by random traffic.
    initial begin
        logic [N-1:0] g;
        logic [N-1:0] prev;
        int           cnt;
        int           to_cnt;
        int           order_q[$];
        logic [N-1:0] og[23];
        logic         ot[23];
        int           hi;

        arb.req   = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_grant",    int'(arb.grant),    0);
        chk("rst_grant_id", int'(arb.grant_id), 0);
        chk("rst_busy",     int'(arb.busy),     0);
        chk("rst_timeout",  int'(arb.timeout),  0);
        sys_rst_n = 1'b1;

        // Single requester, held for 5 cycles.
        @(negedge sys_clk);
        arb.req = 4'b0001;
        to_cnt  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("single_grant", int'(arb.grant), 1);
            chk("single_busy",  int'(arb.busy),  1);
            if (arb.timeout) to_cnt++;
        end
        arb.req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            chk("single_gap", int'(arb.grant), 0);
            if (arb.timeout) to_cnt++;
        end
        chk("single_no_timeout", to_cnt, 0);

        // Round-robin fairness: each owner drops its bit after 3 grant cycles.
        do_reset();
        prev = '0;
        cnt  = 0;
        order_q.delete();
        arb.req = 4'b1111;
        for (int i = 0; i < 26; i++) begin
            @(negedge sys_clk);
            g = arb.grant;
            if (g != '0 && prev == '0) order_q.push_back(int'(g));
            cnt     = (g != '0) ? cnt + 1 : 0;
            arb.req = (cnt == 3) ? (4'b1111 & ~g) : 4'b1111;
            prev    = g;
        end
        chk("rr_count", (order_q.size() >= 5) ? 1 : 0, 1);
        if (order_q.size() >= 5) begin
            chk("rr_order0", order_q[0], 1);
            chk("rr_order1", order_q[1], 2);
            chk("rr_order2", order_q[2], 4);
            chk("rr_order3", order_q[3], 8);
            chk("rr_order4", order_q[4], 1);
        end

        // Forced release at MAX_HOLD.
        do_reset();
        @(negedge sys_clk);
        arb.req = 4'b0100;
        for (int i = 0; i < 23; i++) begin
            @(negedge sys_clk);
            og[i] = arb.grant;
            ot[i] = arb.timeout;
        end
        repeat (17) @(negedge sys_clk);
        arb.req = 4'b0000;
        hi = 0;
        for (int i = 0; i < 22; i++) if (og[i] == 4'b0100) hi++;
        chk("to_hold_cycles",  hi, MAX_HOLD);
        chk("to_pre_pulse",    int'(ot[19]), 0);
        chk("to_pulse",        int'(ot[20]), 1);
        chk("to_pulse_grant",  int'(og[20]), 0);
        chk("to_pulse_end",    int'(ot[21]), 0);
        chk("to_regrant",      int'(og[22]), 4);

        // Timeout fairness between walkers 0 and 2.
        do_reset();
        prev   = '0;
        to_cnt = 0;
        order_q.delete();
        arb.req = 4'b0101;
        for (int i = 0; i < 70; i++) begin
            @(negedge sys_clk);
            g = arb.grant;
            if (g != '0 && prev == '0) order_q.push_back(int'(g));
            if (arb.timeout) to_cnt++;
            prev = g;
        end
        chk("tf_timeouts", to_cnt, 3);
        chk("tf_count", (order_q.size() >= 3) ? 1 : 0, 1);
        if (order_q.size() >= 3) begin
            chk("tf_order0", order_q[0], 1);
            chk("tf_order1", order_q[1], 4);
            chk("tf_order2", order_q[2], 1);
        end

        // Asynchronous reset while walker 1 owns the shovel.
        do_reset();
        @(negedge sys_clk);
        arb.req = 4'b0010;
        @(negedge sys_clk);
        chk("ar_pre_grant", int'(arb.grant), 2);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_grant",    int'(arb.grant),    0);
        chk("ar_grant_id", int'(arb.grant_id), 0);
        chk("ar_busy",     int'(arb.busy),     0);
        chk("ar_timeout",  int'(arb.timeout),  0);
        @(negedge sys_clk);
        arb.req   = 4'b1000;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ar_post_grant",    int'(arb.grant),    8);
        chk("ar_post_grant_id", int'(arb.grant_id), 3);

        // Late requester does not preempt the current owner.
        do_reset();
        @(negedge sys_clk);
        arb.req = 4'b0001;
        repeat (2) @(negedge sys_clk);
        arb.req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("late_hold", int'(arb.grant), 1);
        end
        arb.req = 4'b1000;
        @(negedge sys_clk);
        chk("late_gap0", int'(arb.grant), 0);
        @(negedge sys_clk);
        chk("late_gap1", int'(arb.grant), 0);
        @(negedge sys_clk);
        chk("late_grant", int'(arb.grant), 8);

        // Random traffic: requests change occasionally, checked by the scoreboard.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            @(negedge sys_clk);
            if ($urandom_range(0, 3) == 0) arb.req = 4'($urandom_range(0, 15));
        end

        arb.req = '0;
        repeat (4) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lemming_dig_arbiter.md
# lemming_dig_arbiter

Round-robin arbiter that shares the single dig resource (shovel) among N lemming walker FSMs. Each walker raises its request while it wants to dig. The arbiter grants the shovel to exactly one walker at a time and enforces a maximum hold time. It also enforces a cooldown gap between owners. The arbiter sits between the walker FSM instances and the dig datapath, and its registered one-hot grant gates each walker's dig state.

## Interface
- N, 4, number of requesting walkers (2..8)
- MAX_HOLD, 20, maximum consecutive cycles one walker may hold the grant (1..255)
- ID_W, 2, width of grant_id; must equal clog2(N)
- sys_clk  input  1  clock, all state updates on rising edge
- sys_rst_n  input  1  reset, asynchronous and active-low
- req  input  N  per-walker request, level; bit i high = walker i wants the shovel
- grant  output  N  registered one-hot grant; all-zero when nobody owns the shovel
- grant_id  output  ID_W  index of current owner; 0 when grant is all-zero
- busy  output  1  high while in state GRANT
- timeout  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD

## Operation
- States: IDLE, GRANT, COOLDOWN; 2-bit encoding, reset state IDLE.
- Internal registers:
  - ptr (ID_W bits): round-robin start index, reset 0.
  - owner (ID_W bits): reset 0.
  - hold_cnt: clog2(MAX_HOLD+1) bits, reset 0.
- IDLE:
  - If req is all-zero, stay in IDLE.
  - Otherwise select the first i with req[i]=1, scanning ptr, ptr+1, … wrapping mod N.
  - Load owner=i and hold_cnt=1, then go to GRANT.
- GRANT:
  - If req[owner]=0, go to COOLDOWN (normal release).
  - Else if hold_cnt==MAX_HOLD, go to COOLDOWN and assert timeout.
  - Else increment hold_cnt.
  - Requests from other walkers are ignored while in GRANT; there is no preemption.
- COOLDOWN:
  - Lasts exactly one cycle and moves unconditionally to IDLE.
  - On entry, ptr = (owner+1) mod N, so the last owner has lowest priority in the next arbitration.
- Output registers:
  - grant[owner]=1 only while state==GRANT.
  - grant_id=owner while in GRANT, else 0.
  - busy is high iff state==GRANT.
- timeout is a registered pulse, high for the single COOLDOWN cycle that follows a forced release. Otherwise it is 0.
- A walker that timed out and keeps req high re-competes normally. It wins again only if no other walker is requesting.
- Reset values: grant=0, grant_id=0, busy=0, timeout=0, state=IDLE, ptr=0, owner=0, hold_cnt=0.

## Timing
- Grant latency: req[i] high and sampled at edge t while IDLE → grant[i]=1 after edge t (1 cycle).
- Hold accounting: hold_cnt equals the number of grant-high cycles elapsed including the current one. The grant is therefore high for at most MAX_HOLD cycles.
- Normal release: req[owner] low at edge t → grant=0 after edge t (COOLDOWN), IDLE after t+1. The earliest next grant is after edge t+2.
- Forced release: grant high after edges t..t+MAX_HOLD-1 → grant=0 and timeout=1 after edge t+MAX_HOLD, timeout=0 after edge t+MAX_HOLD+1.
- Minimum gap between two grants is 2 cycles with grant all-zero.
- Simultaneous requests in IDLE are resolved in one cycle by rotating priority from ptr. The result is never more than one grant bit.
- A req pulse shorter than one cycle, or one that falls before being sampled, is never granted.
- Reset mid-operation: sys_rst_n low clears all outputs immediately, without waiting for a clock edge. The first arbitration after reset deasserts occurs at the first rising edge with sys_rst_n high.
- N not a power of two: the wrap is mod N, and indices ≥ N are never produced.

## Test plan
- Single requester: N=4, MAX_HOLD=20, req=0001 held for 5 cycles, then 0000. Expect:
  - grant=0001 and grant_id=0 after 1 cycle, held 5 cycles, busy=1.
  - grant=0000 for 2 cycles, timeout never asserted.
- Round-robin fairness: req=1111 held continuously, each owner releasing after 3 cycles by dropping its own bit for 1 cycle. Expect grant order 0001 → 0010 → 0100 → 1000 → 0001, with a 2-cycle gap each time.
- Timeout: MAX_HOLD=20, req=0100 held 40 cycles. Expect:
  - grant=0100 for exactly 20 cycles, then timeout=1 for 1 cycle with grant=0000.
  - Re-grant to walker 2 two cycles after the release.
- Timeout fairness: req=0101 held constantly. Expect owners to alternate 0 → 2 → 0, each for 20 cycles with a timeout pulse between them.
- Async reset mid-grant: assert sys_rst_n=0 between clock edges while grant=0010. Expect grant=0, busy=0, timeout=0 immediately. After release with req=1000, expect grant=1000 one cycle later, with ptr restarted at 0.
- Late requester ignored: owner 0 granted, req[3] rises mid-grant. Expect no grant change until owner 0 releases, then grant=1000 after the 2-cycle gap.
